inv_sqrt_nr_core: RTL and testbench

Computes y ≈ 1/sqrt(x) for an IEEE 754 single-precision input.
- Seed: magic-constant bit trick.
- Refinement: ITERATIONS Newton-Raphson steps, using one shared truncating float multiplier.
- Sits directly downstream of the fixed-to-single converter in the fastInvSqrt peripheral and consumes its data_out/valid_out through the same valid/ready handshake.

---
 rtl/inv_sqrt_nr_core.sv | 230 +++++++++++++++++++++++
 tb/tb_inv_sqrt_nr_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sqrt_nr_core.sv
// Fast inverse square root: magic-constant seed refined by Newton-Raphson
// steps that share one truncating single-precision multiplier.
module inv_sqrt_nr_core #(
    parameter logic [31:0] MAGIC      = 32'h5F3759DF,
    parameter int unsigned ITERATIONS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] data_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] data_out
);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_H,
        MUL_T,
        SUB,
        MUL_Y,
        DONE
    } state_t;

    localparam logic [25:0] THREE_HALVES_Q = 26'h1800000;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] xh_q, xh_d;
    logic [31:0] y_q, y_d;
    logic [31:0] tmp_q, tmp_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ready_in_q, ready_in_d;
    logic        valid_out_q, valid_out_d;
    logic [31:0] data_out_q, data_out_d;

    logic [31:0] mul_a, mul_b, prod, seed, f_val;

    // Positive-operand multiply: truncated mantissa, zero on exponent-0 input or underflow.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            return '0;
        end
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (p[47]) begin
            m = 23'(p >> 24);
            e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd126;
        end else begin
            m = 23'(p >> 23);
            e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        end
        if (e <= 10'sd0) begin
            return '0;
        end
        if (e >= 10'sd255) begin
            return 32'h7F800000;
        end
        return {1'b0, e[7:0], m};
    endfunction

    // 1.5 - t evaluated in Q2.24 fixed point, then renormalised to single precision.
    function automatic logic [31:0] three_halves_minus(input logic [31:0] t);
        logic [7:0]  et;
        logic [7:0]  sh;
        logic [25:0] tq;
        logic [25:0] diff;
        logic [25:0] norm;
        logic [4:0]  k;
        et = t[30:23];
        if (et > 8'd127) begin
            return '0;
        end
        sh = 8'd127 - et;
        if (sh >= 8'd26) begin
            tq = '0;
        end else begin
            tq = {1'b0, 1'b1, t[22:0], 1'b0} >> sh;
        end
        if (tq >= THREE_HALVES_Q) begin
            return '0;
        end
        diff = THREE_HALVES_Q - tq;
        k = '0;
        for (int unsigned i = 0; i < 26; i++) begin
            if (diff[i]) begin
                k = 5'(i);
            end
        end
        norm = diff << (5'd25 - k);
        return {1'b0, 8'd103 + {3'b000, k}, 23'(norm >> 2)};
    endfunction

    always_comb begin
        mul_a = y_q;
        mul_b = tmp_q;
        case (state_q)
            MUL_H: begin
                mul_a = xh_q;
                mul_b = y_q;
            end
            MUL_T: begin
                mul_a = tmp_q;
                mul_b = y_q;
            end
            default: ;
        endcase
    end

    assign prod  = fmul(mul_a, mul_b);
    assign seed  = MAGIC - (x_q >> 1);
    assign f_val = three_halves_minus(tmp_q);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        xh_d        = xh_q;
        y_d         = y_q;
        tmp_d       = tmp_q;
        cnt_d       = cnt_q;
        ready_in_d  = 1'b0;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;

        case (state_q)
            IDLE: begin
                ready_in_d = 1'b1;
                if (valid_in && ready_in_q) begin
                    x_d        = data_in;
                    ready_in_d = 1'b0;
                    state_d    = SEED;
                end
            end
            SEED: begin
                // Special operands bypass refinement and finish here.
                if (x_q[30:23] == 8'd0) begin
                    data_out_d  = 32'h7F800000;
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end else if (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0) begin
                    data_out_d  = 32'h7FC00000;
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end else if (x_q[31]) begin
                    data_out_d  = 32'h7FC00000;
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end else if (x_q[30:23] == 8'hFF) begin
                    data_out_d  = 32'h00000000;
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    y_d   = seed;
                    xh_d  = {x_q[31], x_q[30:23] - 8'd1, x_q[22:0]};
                    cnt_d = 2'(ITERATIONS);
                    if (ITERATIONS == 0) begin
                        data_out_d  = seed;
                        valid_out_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = MUL_H;
                    end
                end
            end
            MUL_H: begin
                tmp_d   = prod;
                state_d = MUL_T;
            end
            MUL_T: begin
                tmp_d   = prod;
                state_d = SUB;
            end
            SUB: begin
                tmp_d   = f_val;
                state_d = MUL_Y;
            end
            MUL_Y: begin
                y_d   = prod;
                cnt_d = cnt_q - 2'd1;
                if (cnt_d != 2'd0) begin
                    state_d = MUL_H;
                end else begin
                    data_out_d  = prod;
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (ready_out) begin
                    valid_out_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            xh_q        <= '0;
            y_q         <= '0;
            tmp_q       <= '0;
            cnt_q       <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            xh_q        <= xh_d;
            y_q         <= y_d;
            tmp_q       <= tmp_d;
            cnt_q       <= cnt_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign ready_in  = ready_in_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_inv_sqrt_nr_core.sv
// Bench for inv_sqrt_nr_core: ITERATIONS=0 instance for exact seed values,
// default instance checked for accuracy against real-valued 1/sqrt(x).
module tb_inv_sqrt_nr_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  vin = '0;
    logic [1:0]  rin;
    logic [1:0]  vout;
    logic [1:0]  rout = 2'b11;
    logic [31:0] din[2];
    logic [31:0] dout[2];

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    inv_sqrt_nr_core #(.ITERATIONS(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vin[0]), .ready_in(rin[0]), .data_in(din[0]),
        .valid_out(vout[0]), .ready_out(rout[0]), .data_out(dout[0])
    );

    inv_sqrt_nr_core #(.ITERATIONS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vin[1]), .ready_in(rin[1]), .data_in(din[1]),
        .valid_out(vout[1]), .ready_out(rout[1]), .data_out(dout[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        if (e > 127) begin
            for (int i = 0; i < e - 127; i++) v = v * 2.0;
        end else begin
            for (int i = 0; i < 127 - e; i++) v = v / 2.0;
        end
        return v;
    endfunction

    // Relative error bound between y and 1/sqrt(x)
    task automatic check_tol(input string tag, input logic [31:0] x, input logic [31:0] y);
        real err;
        err = f2r(y) * $sqrt(f2r(x)) - 1.0;
        if (err < 0.0) err = -err;
        ncmp++;
        assert (y[31] == 1'b0 && y[30:23] != 8'd0 && y[30:23] != 8'hFF && err <= 0.002) else begin
            nerr++;
            $error("FAIL %s: x=%h got %h relerr=%f limit 0.002", tag, x, y, err);
        end
    endtask

    // One transaction on instance s with ready_out held high; lat counts edges incl. the accept edge
    task automatic op(input int s, input logic [31:0] x, output logic [31:0] y, output int lat);
        int n;
        @(negedge clk);
        vin[s] = 1'b1;
        din[s] = x;
        n = 0;
        while (!rin[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(rin[s]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        vin[s] = 1'b0;
        lat = 1;
        while (!vout[s] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        y = dout[s];
    endtask

    logic [31:0] y, x, sd;
    int          lat;
    logic [31:0] sweep[7] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3E800000,
                              32'h447A0000, 32'h00800000, 32'h7F000000};
    logic [31:0] spec_in[6]  = '{32'h00000000, 32'h80000000, 32'h00000001,
                                 32'hBF800000, 32'h7F800000, 32'h7FC00001};
    logic [31:0] spec_out[6] = '{32'h7F800000, 32'h7F800000, 32'h7F800000,
                                 32'h7FC00000, 32'h00000000, 32'h7FC00000};
    logic [31:0] ops[8];
    logic [31:0] res[8];
    int          acc_t[8];

    initial begin
        din[0] = '0;
        din[1] = '0;

        // Reset state
        #2;
        check("rst_ready_in", 32'(rin), 32'd0);
        check("rst_valid_out", 32'(vout), 32'd0);
        check("rst_data_out0", dout[0], 32'h0);
        check("rst_data_out1", dout[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_before_edge", 32'(rin), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(rin), 32'd3);

        // Seed only
        op(0, 32'h3F800000, y, lat);
        check("it0_one", y, 32'h3F7759DF);
        check("it0_one_lat", 32'(lat), 32'd2);
        op(0, 32'h40800000, y, lat);
        check("it0_four", y, 32'h3EF759DF);
        check("it0_four_lat", 32'(lat), 32'd2);

        // One Newton step, directed sweep
        foreach (sweep[i]) begin
            op(1, sweep[i], y, lat);
            check("it1_sweep_lat", 32'(lat), 32'd6);
            if (sweep[i][30:23] == 8'd1) begin
                // xh underflows to zero here, so the step scales the seed by exactly 1.5
                sd = 32'h5F3759DF - (sweep[i] >> 1);
                ncmp++;
                assert (f2r(y) / (1.5 * f2r(sd)) - 1.0 <= 2.4e-7 &&
                        f2r(y) / (1.5 * f2r(sd)) - 1.0 >= -2.4e-7) else begin
                    nerr++;
                    $error("FAIL it1_min_normal: got %h expected about 1.5*%h", y, sd);
                end
            end else begin
                check_tol("it1_sweep", sweep[i], y);
            end
        end

        // Random positive normals
        for (int i = 0; i < 2000; i++) begin
            x = {1'b0, 8'($urandom_range(254, 2)), 23'($urandom)};
            op(1, x, y, lat);
            check_tol("it1_rand", x, y);
            check("it1_rand_lat", 32'(lat), 32'd6);
        end

        // Special operands
        foreach (spec_in[i]) begin
            op(1, spec_in[i], y, lat);
            check("special", y, spec_out[i]);
            check("special_lat", 32'(lat), 32'd2);
        end

        // Backpressure held in DONE
        rout[0] = 1'b0;
        op(0, 32'h40800000, y, lat);
        check("bp_first", y, 32'h3EF759DF);
        for (int i = 0; i < 20; i++) begin
            vin[0] = ~vin[0];
            din[0] = 32'h3F800000;
            @(negedge clk);
            check("bp_valid", 32'(vout[0]), 32'd1);
            check("bp_data", dout[0], 32'h3EF759DF);
            check("bp_ready_in", 32'(rin[0]), 32'd0);
        end
        vin[0]  = 1'b0;
        rout[0] = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(vout[0]), 32'd0);
        check("bp_release_data", dout[0], 32'h3EF759DF);
        check("bp_release_ready", 32'(rin[0]), 32'd0);
        @(negedge clk);
        check("bp_ready_next", 32'(rin[0]), 32'd1);
        check("bp_no_accept", 32'(vout[0]), 32'd0);

        // Reset in the middle of a computation
        @(negedge clk);
        vin[1] = 1'b1;
        din[1] = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        vin[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rin), 32'd0);
        check("midrst_valid", 32'(vout), 32'd0);
        check("midrst_data0", dout[0], 32'h0);
        check("midrst_data1", dout[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op(1, 32'h40800000, y, lat);
        check_tol("after_rst_it1", 32'h40800000, y);
        check("after_rst_lat", 32'(lat), 32'd6);
        op(0, 32'h40800000, y, lat);
        check("after_rst_it0", y, 32'h3EF759DF);

        // Back-to-back stream with valid_in held high
        for (int i = 0; i < 8; i++) ops[i] = {1'b0, 8'($urandom_range(200, 40)), 23'($urandom)};
        begin
            int na;
            int nr;
            logic acc_now;
            na = 0;
            nr = 0;
            for (int c = 0; c < 200 && nr < 8; c++) begin
                @(negedge clk);
                if (vout[1]) begin
                    res[nr] = dout[1];
                    nr++;
                end
                if (na < 8) begin
                    vin[1] = 1'b1;
                    din[1] = ops[na];
                end else begin
                    vin[1] = 1'b0;
                end
                acc_now = rin[1] && vin[1];
                @(posedge clk);
                if (acc_now) begin
                    acc_t[na] = c;
                    na++;
                end
            end
            vin[1] = 1'b0;
            check("stream_accepts", 32'(na), 32'd8);
            check("stream_results", 32'(nr), 32'd8);
            for (int i = 0; i < nr; i++) check_tol("stream_result", ops[i], res[i]);
            for (int i = 1; i < na; i++) check("stream_interval", 32'(acc_t[i] - acc_t[i-1]), 32'd8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
